// File: rtl/acc_ctrl_seq.sv
// acc_ctrl_seq: fetch/decode/execute sequencer for the accumulator processor.
// Moore state with Mealy enables on mem_ready; halts on illegal opcode or memory timeout.
module acc_ctrl_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);
  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] FETCH  = 3'b001;
  localparam logic [2:0] DECODE = 3'b010;
  localparam logic [2:0] EXEC   = 3'b011;
  localparam logic [2:0] MEM    = 3'b100;
  localparam logic [2:0] HALT   = 3'b111;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JN  = 4'h8;
  localparam logic [3:0] OP_CLA = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_BAD = 4'hB;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;
  localparam logic [2:0] ALU_CLR  = 3'b101;
  logic [3:0] op_r;
  logic [7:0] timer;
  logic [2:0] next;
  logic       is_fetch, is_mem, is_exec, is_sta;
  logic       waiting, expired, dec_mem, dec_bad;
  assign is_fetch = state == FETCH;
  assign is_mem   = state == MEM;
  assign is_exec  = state == EXEC;
  assign is_sta   = op_r == OP_STA;
  assign waiting  = (is_fetch || is_mem) && !mem_ready;
  assign expired  = waiting && timer == 8'(TIMEOUT - 1);
  assign dec_mem  = opcode >= OP_LDA && opcode <= OP_AND;
  assign dec_bad  = opcode >= OP_BAD && opcode != 4'hF;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = run ? FETCH : IDLE;
      FETCH:   next = mem_ready ? DECODE : expired ? HALT : FETCH;
      DECODE:  next = dec_mem ? MEM : opcode >= OP_BAD ? HALT : EXEC;
      EXEC:    next = run ? FETCH : IDLE;
      MEM:     next = mem_ready ? (run ? FETCH : IDLE) : expired ? HALT : MEM;
      HALT:    next = HALT;
      default: next = IDLE;
    endcase
  end
  // timer only survives a cycle that waits and stays put; any move clears it
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state   <= IDLE;
      op_r    <= '0;
      timer   <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= next;
      timer <= (waiting && next == state) ? timer + 8'd1 : 8'd0;
      if (state == DECODE) op_r <= opcode;
      if (state == DECODE && dec_bad) illegal <= 1'b1;
      if (expired) bus_err <= 1'b1;
    end
  assign mem_rd   = is_fetch || (is_mem && !is_sta);
  assign mem_wr   = is_mem && is_sta;
  assign addr_sel = is_mem;
  assign ir_load  = is_fetch && mem_ready;
  assign pc_inc   = is_fetch && mem_ready;
  assign pc_load  = is_exec && (op_r == OP_JMP || (op_r == OP_JZ && acc_zero) || (op_r == OP_JN && acc_neg));
  assign acc_load = (is_mem && mem_ready && !is_sta) || (is_exec && (op_r == OP_CLA || op_r == OP_NOT));
  assign alu_op   = !acc_load ? ALU_PASS :
                    is_exec ? (op_r == OP_CLA ? ALU_CLR : ALU_NOT) :
                    op_r == OP_ADD ? ALU_ADD :
                    op_r == OP_SUB ? ALU_SUB :
                    op_r == OP_AND ? ALU_AND : ALU_PASS;
  assign halted   = state == HALT;
endmodule

// File: tb/tb_acc_ctrl_seq.sv
// tb_acc_ctrl_seq: builds an expected per-cycle trace from instruction-level rules and replays it.
module tb_acc_ctrl_seq;
  localparam int TO = 4;
  typedef struct packed {
    logic        run;
    logic        rdy;
    logic [3:0]  op;
    logic        az;
    logic        an;
    logic [15:0] exp;
  } step_t;
  logic clk = 1'b0, clr = 1'b1, run = 1'b0, acc_zero = 1'b0, acc_neg = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load, halted, illegal, bus_err;
  logic [2:0] alu_op, state;
  logic [15:0] got;
  logic m_ill = 1'b0, m_be = 1'b0;
  int checks = 0, errors = 0;
  step_t q[$];
  acc_ctrl_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode), .acc_zero(acc_zero), .acc_neg(acc_neg),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .alu_op(alu_op), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );
  always #5 clk = ~clk;
  assign got = {state, mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op, halted, illegal, bus_err};
  function automatic logic [15:0] mk(input logic [2:0] st, input logic rd, wr, as, irl, pci, pcl, ld, input logic [2:0] alu);
    return {st, rd, wr, as, irl, pci, pcl, ld, alu, st == 3'b111, m_ill, m_be};
  endfunction
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s #%0d got %h expected %h at %0t", tag, checks, act, exp, $time);
    end
  endtask
  task automatic push(input logic r, input logic rdy, input logic [3:0] op, input logic az, input logic an, input logic [15:0] exp);
    q.push_back('{r, rdy, op, az, an, exp});
  endtask
  task automatic add_idle(input logic r);
    push(r, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'h0000);
  endtask
  task automatic add_halt(input int n);
    repeat (n) push(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
  endtask
  // one instruction: wf/wm not-ready cycles before ready in fetch/operand access (>= TO means timeout)
  task automatic add_instr(input logic [3:0] op, input int wf, input int wm, input logic az, input logic an, input logic stop);
    logic r, ld, pl;
    logic [2:0] alu;
    int n;
    n = wf < TO ? wf + 1 : TO;
    for (int i = 0; i < n; i++) begin
      r = (i == wf);
      push(1'b1, r, 4'($urandom), 1'($urandom), 1'($urandom), mk(3'd1, 1'b1, 1'b0, 1'b0, r, r, 1'b0, 1'b0, 3'd0));
    end
    if (wf >= TO) begin
      m_be = 1'b1;
      add_halt(3);
      return;
    end
    push(1'b1, 1'($urandom), op, az, an, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    if (op == 4'hF) begin
      add_halt(3);
      return;
    end
    if (op > 4'hA) begin
      m_ill = 1'b1;
      add_halt(3);
      return;
    end
    if (op >= 4'h1 && op <= 4'h5) begin
      n = wm < TO ? wm + 1 : TO;
      for (int i = 0; i < n; i++) begin
        r = (i == wm);
        ld = r && op != 4'h2;
        alu = (!ld || op == 4'h1) ? 3'd0 : 3'(op - 4'h2);
        push(!stop, r, op, az, an, mk(3'd4, op != 4'h2, op == 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, ld, alu));
      end
      if (wm >= TO) begin
        m_be = 1'b1;
        add_halt(3);
        return;
      end
    end else begin
      pl = op == 4'h6 || (op == 4'h7 && az) || (op == 4'h8 && an);
      ld = op == 4'h9 || op == 4'hA;
      alu = op == 4'h9 ? 3'b101 : op == 4'hA ? 3'b100 : 3'b000;
      push(!stop, 1'($urandom), op, az, an, mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pl, ld, alu));
    end
    if (stop) begin
      repeat (1 + $urandom_range(0, 1)) add_idle(1'b0);
      add_idle(1'b1);
    end
  endtask
  task automatic play();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      run = s.run;
      mem_ready = s.rdy;
      opcode = s.op;
      acc_zero = s.az;
      acc_neg = s.an;
      #1 check("trace", got, s.exp);
    end
  endtask
  // asynchronous clear between edges; outputs must drop before any clock
  task automatic pulse_clr();
    clr = 1'b1;
    run = 1'b0;
    #1 check("clr", got, 16'h0000);
    clr = 1'b0;
    m_ill = 1'b0;
    m_be = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    #1 check("reset", got, 16'h0000);
    clr = 1'b0;
    add_idle(1'b1);
    add_instr(4'h1, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'h3, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'h2, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b0);
    play();
    pulse_clr();
    add_idle(1'b1);
    add_instr(4'h7, 0, 0, 1'b0, 1'b1, 1'b0);
    add_instr(4'h7, 0, 0, 1'b1, 1'b0, 1'b0);
    add_instr(4'h8, 0, 0, 1'b0, 1'b1, 1'b0);
    add_instr(4'h8, 0, 0, 1'b1, 1'b0, 1'b0);
    add_instr(4'h6, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'h9, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'hA, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'h0, 3, 0, 1'b0, 1'b0, 1'b0);
    add_instr(4'h4, 1, 2, 1'b0, 1'b0, 1'b0);
    add_instr(4'h5, 0, 3, 1'b0, 1'b0, 1'b0);
    add_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b0);
    play();
    pulse_clr();
    add_idle(1'b1);
    push(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    play();
    pulse_clr();
    add_idle(1'b1);
    add_instr(4'h1, 0, TO + 5, 1'b0, 1'b0, 1'b0);
    add_halt(6);
    play();
    pulse_clr();
    add_idle(1'b1);
    add_instr(4'h0, TO, 0, 1'b0, 1'b0, 1'b0);
    play();
    pulse_clr();
    add_idle(1'b1);
    add_instr(4'hB, 0, 0, 1'b0, 1'b0, 1'b0);
    play();
    pulse_clr();
    add_idle(1'b1);
    add_instr(4'h1, 0, 2, 1'b0, 1'b0, 1'b1);
    add_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b0);
    play();
    pulse_clr();
    for (int k = 0; k < 8; k++) begin
      add_idle(1'b1);
      repeat (40) add_instr(4'($urandom_range(0, 10)), $urandom_range(0, 3), $urandom_range(0, 3),
                            1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: add_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b0);
        1: add_instr(4'hB + 4'($urandom_range(0, 3)), 0, 0, 1'b0, 1'b0, 1'b0);
        default: add_instr(4'h3, 0, TO, 1'b0, 1'b0, 1'b0);
      endcase
      play();
      pulse_clr();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
